// File: rtl/md5_pkg.sv
// md5_pkg: shared definitions for the MD5 demo core.
//   - FSM state encoding
//   - initial chaining values H0..H3
//   - per-step additive constants K and rotate amounts s
//   - pre-padded message ROM (4 messages x up to 2 blocks x 16 words)
//     and the last-block index of each message
//   - small helpers: rotate-left and byte swap
package md5_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] H0_INIT = 32'h67452301;
  localparam logic [31:0] H1_INIT = 32'hefcdab89;
  localparam logic [31:0] H2_INIT = 32'h98badcfe;
  localparam logic [31:0] H3_INIT = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // The s table repeats every 4 steps within a round, so it is indexed by
  // {round, step mod 4} rather than stored as 64 entries.
  function automatic logic [4:0] s_of(input logic [5:0] i);
    logic [4:0] s;
    case ({i[5:4], i[1:0]})
      4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
      4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
      4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
      4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Index of the last block of each message (0 = one block, 1 = two blocks).
  function automatic logic last_blk(input logic [1:0] sel);
    logic l;
    case (sel)
      2'd0:    l = 1'b0;
      2'd1:    l = 1'b0;
      2'd2:    l = 1'b1;
      default: l = 1'b1;
    endcase
    return l;
  endfunction

  // Padded message ROM. Words are little-endian byte packs of the message;
  // every word not listed is zero (padding body).
  function automatic logic [31:0] msg_word(input logic [1:0] sel, input logic blk,
                                           input logic [3:0] idx);
    logic [31:0] w;
    case ({sel, blk, idx})
      // "" : 0x80 then bit length 0
      {2'd0, 1'b0, 4'd0}:  w = 32'h00000080;
      // "abc" : length 24 bits
      {2'd1, 1'b0, 4'd0}:  w = 32'h80636261;
      {2'd1, 1'b0, 4'd14}: w = 32'h00000018;
      // "A..Za..z0..9" (62 bytes) : length 496 bits in second block
      {2'd2, 1'b0, 4'd0}:  w = 32'h44434241;
      {2'd2, 1'b0, 4'd1}:  w = 32'h48474645;
      {2'd2, 1'b0, 4'd2}:  w = 32'h4c4b4a49;
      {2'd2, 1'b0, 4'd3}:  w = 32'h504f4e4d;
      {2'd2, 1'b0, 4'd4}:  w = 32'h54535251;
      {2'd2, 1'b0, 4'd5}:  w = 32'h58575655;
      {2'd2, 1'b0, 4'd6}:  w = 32'h62615a59;
      {2'd2, 1'b0, 4'd7}:  w = 32'h66656463;
      {2'd2, 1'b0, 4'd8}:  w = 32'h6a696867;
      {2'd2, 1'b0, 4'd9}:  w = 32'h6e6d6c6b;
      {2'd2, 1'b0, 4'd10}: w = 32'h7271706f;
      {2'd2, 1'b0, 4'd11}: w = 32'h76757473;
      {2'd2, 1'b0, 4'd12}: w = 32'h7a797877;
      {2'd2, 1'b0, 4'd13}: w = 32'h33323130;
      {2'd2, 1'b0, 4'd14}: w = 32'h37363534;
      {2'd2, 1'b0, 4'd15}: w = 32'h00803938;
      {2'd2, 1'b1, 4'd14}: w = 32'h000001f0;
      // "1234567890" x 8 (80 bytes) : length 640 bits in second block
      {2'd3, 1'b0, 4'd0}, {2'd3, 1'b0, 4'd5}, {2'd3, 1'b0, 4'd10},
      {2'd3, 1'b0, 4'd15}:                     w = 32'h34333231;
      {2'd3, 1'b0, 4'd1}, {2'd3, 1'b0, 4'd6}, {2'd3, 1'b0, 4'd11},
      {2'd3, 1'b1, 4'd0}:                      w = 32'h38373635;
      {2'd3, 1'b0, 4'd2}, {2'd3, 1'b0, 4'd7}, {2'd3, 1'b0, 4'd12},
      {2'd3, 1'b1, 4'd1}:                      w = 32'h32313039;
      {2'd3, 1'b0, 4'd3}, {2'd3, 1'b0, 4'd8}, {2'd3, 1'b0, 4'd13},
      {2'd3, 1'b1, 4'd2}:                      w = 32'h36353433;
      {2'd3, 1'b0, 4'd4}, {2'd3, 1'b0, 4'd9}, {2'd3, 1'b0, 4'd14},
      {2'd3, 1'b1, 4'd3}:                      w = 32'h30393837;
      {2'd3, 1'b1, 4'd4}:  w = 32'h00000080;
      {2'd3, 1'b1, 4'd14}: w = 32'h00000280;
      default:             w = 32'h00000000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/md5_hex7seg.sv
// hex7seg: one hex nibble to an active-low seven-segment pattern.
// Ports:
//   nibble  in  4  value 0..F
//   seg     out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'ha:    seg = 7'b0001000;
      4'hb:    seg = 7'b0000011;
      4'hc:    seg = 7'b1000110;
      4'hd:    seg = 7'b0100001;
      4'he:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/md5_top.sv
// md5_top: MD5 demo core. Hashes one of four preset ROM messages on start
// and shows a 6-character window of the digest on seven-segment displays.
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  synchronous active-low reset
//   start      in  1  start request, accepted in IDLE or DONE
//   data_sel   in  2  message select, latched on accepted start
//   hex_sel    in  4  window select, window starts at character 2*hex_sel
//   hex0..hex5 out 7  active-low segments, hex5 leftmost
//   done       out 1  digest valid for the last accepted start
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LOAD    | initialise H and a..d, step counter cleared
// ROUND   | one MD5 step per cycle, i = 0..63
// ADD     | fold a..d into H; next block or finish
// DONE    | digest held, done high, start restarts
module md5_top
  import md5_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] data_sel,
  input  logic [3:0] hex_sel,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       done
);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        blk_q, blk_d;
  logic [5:0]  i_q, i_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [31:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
  logic        done_q, done_d;

  logic [31:0] f_val, m_word, step_sum;
  logic [3:0]  g_idx;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    blk_d   = blk_q;
    i_d     = i_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    h0_d = h0_q; h1_d = h1_q; h2_d = h2_q; h3_d = h3_q;
    done_d  = done_q;

    // g is only a function of i mod 16 once the round multiplier is applied
    case (i_q[5:4])
      2'd0: begin
        f_val = (b_q & c_q) | (~b_q & d_q);
        g_idx = i_q[3:0];
      end
      2'd1: begin
        f_val = (b_q & d_q) | (c_q & ~d_q);
        g_idx = i_q[3:0] * 4'd5 + 4'd1;
      end
      2'd2: begin
        f_val = b_q ^ c_q ^ d_q;
        g_idx = i_q[3:0] * 4'd3 + 4'd5;
      end
      default: begin
        f_val = c_q ^ (b_q | ~d_q);
        g_idx = i_q[3:0] * 4'd7;
      end
    endcase
    m_word   = msg_word(sel_q, blk_q, g_idx);
    step_sum = a_q + f_val + K_TAB[i_q] + m_word;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sel_d   = data_sel;
          blk_d   = 1'b0;
          done_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        h0_d = H0_INIT; h1_d = H1_INIT; h2_d = H2_INIT; h3_d = H3_INIT;
        a_d  = H0_INIT; b_d  = H1_INIT; c_d  = H2_INIT; d_d  = H3_INIT;
        i_d  = 6'd0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        a_d = d_q;
        d_d = c_q;
        c_d = b_q;
        b_d = b_q + rotl(step_sum, s_of(i_q));
        i_d = i_q + 6'd1;
        if (i_q == 6'd63) state_d = S_ADD;
      end
      S_ADD: begin
        h0_d = h0_q + a_q; h1_d = h1_q + b_q;
        h2_d = h2_q + c_q; h3_d = h3_q + d_q;
        if (blk_q == last_blk(sel_q)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          blk_d = blk_q + 1'b1;
          a_d = h0_d; b_d = h1_d; c_d = h2_d; d_d = h3_d;
          i_d = 6'd0;
          state_d = S_ROUND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      blk_q   <= 1'b0;
      i_q     <= 6'd0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      h0_q <= '0; h1_q <= '0; h2_q <= '0; h3_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      blk_q   <= blk_d;
      i_q     <= i_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      h0_q <= h0_d; h1_q <= h1_d; h2_q <= h2_d; h3_q <= h3_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

  // Printed digest: each H word emitted low byte first; character 0 is the
  // top nibble of this vector.
  logic [127:0] digest_str;
  logic [3:0]   chars   [32];
  logic [3:0]   win_nib [6];
  logic [4:0]   win_base;
  logic [6:0]   seg     [6];

  always_comb begin
    digest_str = {bswap(h0_q), bswap(h1_q), bswap(h2_q), bswap(h3_q)};
    for (int j = 0; j < 32; j++) chars[j] = digest_str[127 - 4*j -: 4];
    win_base = {hex_sel, 1'b0};
    // 5-bit position arithmetic gives the mod-32 wrap for free
    for (int n = 0; n < 6; n++) win_nib[n] = chars[win_base + 5'(5 - n)];
  end

  for (genvar n = 0; n < 6; n++) begin : g_hex
    hex7seg u_hex7seg (.nibble(win_nib[n]), .seg(seg[n]));
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];

endmodule

// File: tb/tb_md5_top.sv
module tb_md5_top;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [1:0] data_sel;
  logic [3:0] hex_sel;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       done;
  int tests = 0;
  int fails = 0;

  localparam logic [127:0] DG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] DG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] DG_ALNUM = 128'hd174ab98d277d9f5a5611c2c9f419d9f;
  localparam logic [127:0] DG_DIGIT = 128'h57edf4a22be3c955ac49da2e2107b67a;

  always #5 clk = ~clk;

  md5_top dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_sel(data_sel), .hex_sel(hex_sel),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .done(done)
  );

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000; 4'h1: g = 7'b1111001; 4'h2: g = 7'b0100100; 4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001; 4'h5: g = 7'b0010010; 4'h6: g = 7'b0000010; 4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000; 4'h9: g = 7'b0010000; 4'ha: g = 7'b0001000; 4'hb: g = 7'b0000011;
      4'hc: g = 7'b1000110; 4'hd: g = 7'b0100001; 4'he: g = 7'b0000110; default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex_at(input int n);
    logic [6:0] r;
    case (n)
      0: r = hex0; 1: r = hex1; 2: r = hex2; 3: r = hex3; 4: r = hex4; default: r = hex5;
    endcase
    return r;
  endfunction

  // Sweep every window and compare all six displays with the expected string.
  task automatic check_digest(input logic [127:0] exp, input string tag);
    int pos;
    for (int s = 0; s < 16; s++) begin
      hex_sel = 4'(s);
      #1;
      for (int n = 0; n < 6; n++) begin
        pos = (2*s + 5 - n) % 32;
        check($sformatf("%s sel%0d hex%0d", tag, s, n), 32'(hex_at(n)),
              32'(glyph(exp[127 - 4*pos -: 4])));
      end
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, " done"}, 32'(done), 32'd0);
    for (int s = 0; s < 16; s += 9) begin
      hex_sel = 4'(s);
      #1;
      for (int n = 0; n < 6; n++)
        check($sformatf("%s sel%0d hex%0d", tag, s, n), 32'(hex_at(n)), 32'b1000000);
    end
  endtask

  // Pulse start, then count cycles until done. Optional stray start at mid_at.
  task automatic run_hash(input logic [1:0] sel, input int exp_lat, input int mid_at,
                          input string tag);
    int cyc;
    @(negedge clk); data_sel = sel; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mid_at != 0 && cyc == mid_at) begin
        start = 1'b1; data_sel = 2'b00;
      end else start = 1'b0;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; data_sel = 2'd0; hex_sel = 4'd0;
    repeat (3) @(negedge clk);
    check_blank("reset");
    rst_n = 1'b1;

    run_hash(2'd0, 66, 0, "empty");
    hex_sel = 4'd0; #1;
    check("empty hex5", 32'(hex5), 32'b0100001);
    check("empty hex4", 32'(hex4), 32'b0011001);
    check("empty hex3", 32'(hex3), 32'b1111001);
    check("empty hex2", 32'(hex2), 32'b0100001);
    check("empty hex1", 32'(hex1), 32'b0000000);
    check("empty hex0", 32'(hex0), 32'b1000110);
    check_digest(DG_EMPTY, "empty");

    run_hash(2'd1, 66, 0, "abc");
    check_digest(DG_ABC, "abc");
    hex_sel = 4'd15; #1;
    check("abc wrap hex5", 32'(hex5), 32'b1111000);
    check("abc wrap hex4", 32'(hex4), 32'b0100100);
    check("abc wrap hex3", 32'(hex3), 32'b0010000);
    check("abc wrap hex2", 32'(hex2), 32'b1000000);
    check("abc wrap hex1", 32'(hex1), 32'b1000000);
    check("abc wrap hex0", 32'(hex0), 32'b1111001);

    run_hash(2'd2, 131, 0, "alnum");
    check_digest(DG_ALNUM, "alnum");

    run_hash(2'd3, 131, 20, "digits");
    check_digest(DG_DIGIT, "digits");
    repeat (10) @(negedge clk);
    check("done held", 32'(done), 32'd1);

    @(negedge clk); data_sel = 2'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_blank("midrst");
    rst_n = 1'b1;

    run_hash(2'd1, 66, 0, "after_rst");
    check_digest(DG_ABC, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
